// File: rtl/div_seq_8bit.sv
// -----------------------------------------------------------------------------
// div_seq_8bit : sequential 8-bit unsigned restoring divider.
//
// One subtractor_8bit is shared across 8 iterations, producing one quotient
// bit per clock (MSB first). Results are registered and held until the next
// completed operation.
//
// Optional build macro:
//   DIV_SEQ_ABORT_EN : adds an 'abort' input that cancels a running division.
//
// Ports:
//   clk         in   1  rising-edge clock
//   rst         in   1  asynchronous, active-high reset
//   start       in   1  request, sampled only while idle
//   abort       in   1  (DIV_SEQ_ABORT_EN only) cancel while running
//   dividend    in   8  unsigned numerator, captured with start
//   divisor     in   8  unsigned denominator, captured with start
//   busy        out  1  high while iterating
//   done        out  1  one-cycle pulse, results valid
//   quotient    out  8  registered quotient
//   remainder   out  8  registered remainder
//   div_by_zero out  1  registered divide-by-zero flag of the last operation
// -----------------------------------------------------------------------------

// Ripple-borrow 8-bit subtractor: d = a - b, bout = 1 when a < b.
module subtractor_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] d,
  output logic       bout
);

  logic [8:0] brw_s;

  // Bit-serial borrow chain, LSB first.
  always_comb begin
    d        = 8'd0;
    brw_s    = 9'd0;
    for (int i = 0; i < 8; i++) begin
      d[i]       = a[i] ^ b[i] ^ brw_s[i];
      brw_s[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw_s[i]);
    end
    bout = brw_s[8];
  end

endmodule

module div_seq_8bit (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
`ifdef DIV_SEQ_ABORT_EN
  input  logic       abort,
`endif
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t     state_r, state_n_s;
  logic [2:0] count_r;
  // The working remainder never needs bit 7 between iterations: the trial
  // value is bounded by the dividend prefix, so R < 128 whenever it is shifted.
  logic [6:0] r_r;
  logic [7:0] q_r;
  logic [7:0] d_r;
  // Divide-by-zero takes one extra DONE cycle before the done pulse.
  logic       zwait_r;

  logic       busy_r, done_r, dbz_r;
  logic [7:0] quotient_r, remainder_r;

  logic       accept_s, zero_s, run_step_s, fin_s;
  logic [7:0] t_s, sub_d_s, q_n_s, r_n_s;
  logic       sub_bout_s;

  assign t_s = {r_r, q_r[7]};

  subtractor_8bit u_sub (
    .a    (t_s),
    .b    (d_r),
    .d    (sub_d_s),
    .bout (sub_bout_s)
  );

  // Restoring step: keep the difference when it did not borrow.
  always_comb begin
    q_n_s = {q_r[6:0], 1'b0};
    r_n_s = t_s;
    if (sub_bout_s == 1'b0) begin
      q_n_s = {q_r[6:0], 1'b1};
      r_n_s = sub_d_s;
    end else begin
      q_n_s = {q_r[6:0], 1'b0};
      r_n_s = t_s;
    end
  end

  // Next-state and control strobes.
  always_comb begin
    state_n_s = state_r;
    accept_s  = 1'b0;
    zero_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start == 1'b1) begin
          accept_s = 1'b1;
          if (divisor == 8'd0) begin
            zero_s    = 1'b1;
            state_n_s = ST_DONE;
          end else begin
            state_n_s = ST_RUN;
          end
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_RUN: begin
`ifdef DIV_SEQ_ABORT_EN
        if (abort == 1'b1) begin
          state_n_s = ST_IDLE;
        end else if (count_r == 3'd7) begin
          state_n_s = ST_DONE;
        end else begin
          state_n_s = ST_RUN;
        end
`else
        if (count_r == 3'd7) begin
          state_n_s = ST_DONE;
        end else begin
          state_n_s = ST_RUN;
        end
`endif
      end
      ST_DONE: begin
        if (zwait_r == 1'b1) begin
          state_n_s = ST_DONE;
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      default: begin
        state_n_s = ST_IDLE;
      end
    endcase
  end

  // An aborted iteration leaves the working registers untouched.
  assign run_step_s = (state_r == ST_RUN) && (state_n_s != ST_IDLE);
  assign fin_s      = (state_r == ST_RUN) && (state_n_s == ST_DONE);

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      count_r     <= 3'd0;
      r_r         <= 7'd0;
      q_r         <= 8'd0;
      d_r         <= 8'd0;
      zwait_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      dbz_r       <= 1'b0;
      quotient_r  <= 8'd0;
      remainder_r <= 8'd0;
    end else begin
      state_r <= state_n_s;
      busy_r  <= (state_n_s == ST_RUN);
      done_r  <= fin_s | ((state_r == ST_DONE) && zwait_r);
      zwait_r <= zero_s;
      if (accept_s) begin
        q_r     <= dividend;
        d_r     <= divisor;
        r_r     <= 7'd0;
        count_r <= 3'd0;
        dbz_r   <= zero_s;
        if (zero_s) begin
          quotient_r  <= 8'hFF;
          remainder_r <= dividend;
        end
      end else if (run_step_s) begin
        q_r     <= q_n_s;
        r_r     <= r_n_s[6:0];
        count_r <= count_r + 3'd1;
        if (fin_s) begin
          quotient_r  <= q_n_s;
          remainder_r <= r_n_s;
        end
      end
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign div_by_zero = dbz_r;

endmodule
